dlx_ex_sequencer: RTL and testbench
===================================

// Module: dlx_ex_sequencer
// PURPOSE
//  Execute-stage controller for the DLX ALU preprocessor. Accepts one decoded
//  instruction at a time over a valid/ready handshake, drives the preprocessor's
//  en_ex/cntrl_in for one issue cycle, then holds the stage busy for the op's
//  latency (or the serial memory-write window) before retiring it to writeback.
// PARAMETERS
//  ALU_LAT   1   cycles in EXEC for ARITH_LOGIC (3'b001) and MEM_READ (3'b101); 1..15
//  SHF_LAT   2   cycles in EXEC for SHIFT_REG (3'b000); 1..15
//  SER_BITS  32  cycles in SERIAL for MEM_WRITE (3'b100) with imm_regn=1; 1..32
// PORTS
//  clk1         in   1   clock, all state on rising edge
//  rst1_n       in   1   reset, asynchronous, active-low
//  instr_valid  in   1   decoded instruction available
//  instr_ready  out  1   sequencer can accept (combinational: state==IDLE && !flush)
//  instr_cntrl  in   7   {op[2:0], imm_regn, opsel[2:0]}
//  stall        in   1   freeze sequencing (downstream not ready)
//  flush        in   1   synchronous abort of in-flight instruction
//  en_ex        out  1   one-cycle issue strobe to preprocessor
//  cntrl_out    out  7   captured instr_cntrl, valid while en_ex=1, held otherwise
//  ser_active   out  1   high during serial memory-write window
//  ser_idx      out  5   bit index being shifted out, 0..SER_BITS-1
//  done         out  1   one-cycle retire pulse
//  done_err     out  1   with done: opsel was illegal (3'b010,011,110,111, or 100 with imm_regn=0)
//  retire_cnt   out  16  count of done pulses (incl. err), wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (rst1_n=0, async): state=IDLE; en_ex, done, done_err, ser_active=0;
//   cntrl_out=0, ser_idx=0, retire_cnt=0, cycle counter=0. All outputs except
//   instr_ready are registered.
//  FSM: IDLE -> ISSUE -> {EXEC | SERIAL | RETIRE} -> RETIRE -> IDLE.
//  IDLE: handshake = instr_valid && instr_ready; capture instr_cntrl, go ISSUE.
//   stall does not block acceptance in IDLE.
//  ISSUE: if !stall: en_ex=1 next edge output for exactly one cycle, cntrl_out=
//   captured word; decode opsel: ARITH/MEM_READ -> EXEC cnt=ALU_LAT-1;
//   SHIFT -> EXEC cnt=SHF_LAT-1; MEM_WRITE&&imm_regn -> SERIAL cnt=SER_BITS-1,
//   ser_idx=0; illegal -> RETIRE with done_err armed (en_ex still not asserted
//   for illegal ops). If stall: remain ISSUE, en_ex=0.
//  EXEC: if !stall: cnt==0 -> RETIRE else cnt-1. stall holds cnt.
//  SERIAL: ser_active=1; if !stall: ser_idx+1 each cycle; cnt==0 -> RETIRE.
//   stall holds ser_idx and cnt, ser_active stays 1.
//  RETIRE: done=1 (and done_err if armed) for one cycle, retire_cnt+1, -> IDLE.
//   stall is ignored in RETIRE.
//  Latency (no stall, legal op): handshake edge T0; en_ex high cycle T1;
//   done high cycle T1+L+1 where L=ALU_LAT, SHF_LAT or SER_BITS. Next accept
//   earliest at T1+L+2 (instr_ready high in IDLE). Illegal op: done at T2.
//  flush: any state -> IDLE next edge; no done, retire_cnt unchanged, en_ex=0
//   that edge, ser_active=0, ser_idx=0. flush overrides stall and handshake;
//   flush in RETIRE suppresses the done pulse.
//  Simultaneous stall+flush: flush wins. Reset mid-SERIAL: immediate return
//   to reset values, no partial done.
//  cntrl_out holds last issued value between instructions; never cleared except
//   by reset.
// TESTING
//  1 ARITH, cntrl=7'b010_1_001, ALU_LAT=1, valid at T0 -> en_ex@T1 cntrl_out=0x29,
//    done@T3, retire_cnt=1, instr_ready high again @T4.
//  2 MEM_WRITE imm, cntrl=7'b000_1_100, SER_BITS=32 -> ser_active T2..T33,
//    ser_idx 0..31, done@T34; stall 3 cycles at T10 -> done@T37, ser_idx frozen.
//  3 SHIFT with stall held in ISSUE for 2 cycles -> en_ex delayed to T3,
//    exactly one cycle wide; done@T3+SHF_LAT+1.
//  4 Illegal opsel 3'b110 -> en_ex never asserted, done=done_err=1 @T2.
//  5 flush during EXEC and during RETIRE -> IDLE next edge, no done, retire_cnt
//    unchanged; flush with instr_valid in IDLE -> no capture.
//  6 Async reset asserted mid-SERIAL between edges -> all outputs to reset
//    values immediately; retire_cnt wrap from 16'hFFFF to 0 on next retire.

Source files
------------

// File: rtl/dlx_ex_sequencer.sv
// -----------------------------------------------------------------------------
// dlx_ex_sequencer
// Execute-stage controller for the DLX ALU preprocessor. Takes one decoded
// instruction at a time over a valid/ready handshake. It issues the
// instruction to the preprocessor with a one-cycle en_ex strobe, then holds
// the stage busy for the op's latency or for the serial memory-write window.
// Finally it retires the instruction with a one-cycle done pulse.
//
// Ports
//   clk1, rst1_n   clock (rising edge) / asynchronous active-low reset
//   instr_valid    decoded instruction available
//   instr_ready    sequencer can accept (combinational: IDLE and no flush)
//   instr_cntrl    {op[2:0], imm_regn, opsel[2:0]}
//   stall          freeze sequencing (downstream not ready)
//   flush          abort in-flight instruction, back to IDLE next edge
//   en_ex          one-cycle issue strobe to the preprocessor
//   cntrl_out      last issued control word (held between instructions)
//   ser_active     high during the serial memory-write window
//   ser_idx        bit index being shifted out, 0..SER_BITS-1
//   done           one-cycle retire pulse
//   done_err       qualifies done: opsel was illegal
//   retire_cnt     count of done pulses, wraps
//
// Every output except instr_ready is a flop. Each flop is loaded from the
// state the FSM is leaving, so it lags the state register by one cycle.
// -----------------------------------------------------------------------------
module dlx_ex_sequencer #(
  parameter int unsigned ALU_LAT  = 1,   // 1..15
  parameter int unsigned SHF_LAT  = 2,   // 1..15
  parameter int unsigned SER_BITS = 32   // 1..32
) (
  input  logic        clk1,
  input  logic        rst1_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [6:0]  instr_cntrl,
  input  logic        stall,
  input  logic        flush,
  output logic        en_ex,
  output logic [6:0]  cntrl_out,
  output logic        ser_active,
  output logic [4:0]  ser_idx,
  output logic        done,
  output logic        done_err,
  output logic [15:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_EXEC, S_SERIAL, S_RETIRE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU, CLS_SHF, CLS_SER, CLS_ILL
  } op_class_e;

  // Down-counter load values: the counter runs L-1..0, so the FSM stays
  // L cycles in EXEC/SERIAL.
  localparam logic [4:0] ALU_CNT  = 5'(ALU_LAT - 1);
  localparam logic [4:0] SHF_CNT  = 5'(SHF_LAT - 1);
  localparam logic [4:0] SER_LAST = 5'(SER_BITS - 1);

  state_e      state_q, state_d;
  logic [6:0]  instr_q, instr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        en_ex_q, en_ex_d;
  logic [6:0]  cntrl_out_q, cntrl_out_d;
  logic        ser_active_q, ser_active_d;
  logic [4:0]  ser_idx_q, ser_idx_d;
  logic        done_q, done_d;
  logic        done_err_q, done_err_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  op_class_e   op_class;

  // Decode the captured opsel. MEM_WRITE is only legal in its immediate
  // (serial) form.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    op_class = CLS_ILL;
    case (instr_q[2:0])
      3'b000:         op_class = CLS_SHF;
      3'b001, 3'b101: op_class = CLS_ALU;
      3'b100:         op_class = instr_q[3] ? CLS_SER : CLS_ILL;
      default:        op_class = CLS_ILL;
    endcase
  end

  // State register (all flops).
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values;
  // each register, including the captured instruction, has an async reset.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      en_ex_q      <= 1'b0;
      cntrl_out_q  <= '0;
      ser_active_q <= 1'b0;
      ser_idx_q    <= '0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      en_ex_q      <= en_ex_d;
      cntrl_out_q  <= cntrl_out_d;
      ser_active_q <= ser_active_d;
      ser_idx_q    <= ser_idx_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Next-state logic. flush takes priority over stall and over the handshake.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (flush) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_d = instr_cntrl;
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            case (op_class)
              CLS_ALU: begin state_d = S_EXEC;   cnt_d = ALU_CNT;  end
              CLS_SHF: begin state_d = S_EXEC;   cnt_d = SHF_CNT;  end
              CLS_SER: begin state_d = S_SERIAL; cnt_d = SER_LAST; end
              default: begin state_d = S_RETIRE; err_d = 1'b1;     end
            endcase
          end
        end
        S_EXEC, S_SERIAL: begin
          if (!stall) begin
            if (cnt_q == 5'd0) state_d = S_RETIRE;
            else               cnt_d   = cnt_q - 5'd1;
          end
        end
        S_RETIRE: state_d = S_IDLE;  // stall is ignored here
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    en_ex_d      = (state_q == S_ISSUE) && !stall && !flush && (op_class != CLS_ILL);
    cntrl_out_d  = en_ex_d ? instr_q : cntrl_out_q;
    ser_active_d = (state_q == S_SERIAL) && !flush;
    // The bit index is derived from the down-counter. A stall freezes the
    // counter, so it freezes the index as well.
    ser_idx_d    = ser_active_d ? (SER_LAST - cnt_q) : 5'd0;
    done_d       = (state_q == S_RETIRE) && !flush;
    done_err_d   = done_d && err_q;
    retire_cnt_d = retire_cnt_q + 16'(done_d);
  end

  assign instr_ready = (state_q == S_IDLE) && !flush;
  assign en_ex       = en_ex_q;
  assign cntrl_out   = cntrl_out_q;
  assign ser_active  = ser_active_q;
  assign ser_idx     = ser_idx_q;
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_dlx_ex_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dlx_ex_sequencer
// Directed bench for dlx_ex_sequencer with default parameters
// (ALU_LAT=1, SHF_LAT=2, SER_BITS=32). Inputs are driven 1 time unit after a
// rising edge. Registered outputs are sampled at the same point.
//
// Cycle numbering: the edge that takes the handshake is T0. Cycle Tn is the
// interval following the n-th edge after T0.
// -----------------------------------------------------------------------------
module tb_dlx_ex_sequencer;

  logic        clk1 = 1'b0;
  logic        rst1_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [6:0]  instr_cntrl = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        en_ex;
  logic [6:0]  cntrl_out;
  logic        ser_active;
  logic [4:0]  ser_idx;
  logic        done;
  logic        done_err;
  logic [15:0] retire_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_retire = '0;

  always #5 clk1 = ~clk1;

  dlx_ex_sequencer dut (
    .clk1        (clk1),
    .rst1_n      (rst1_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_cntrl (instr_cntrl),
    .stall       (stall),
    .flush       (flush),
    .en_ex       (en_ex),
    .cntrl_out   (cntrl_out),
    .ser_active  (ser_active),
    .ser_idx     (ser_idx),
    .done        (done),
    .done_err    (done_err),
    .retire_cnt  (retire_cnt)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  // Present one instruction. The edge that accepts it becomes T0.
  task automatic issue(input logic [6:0] c);
    instr_valid = 1'b1;
    instr_cntrl = c;
    tick();
    instr_valid = 1'b0;
    cyc = 0;
  endtask

  // Step until done is seen, up to a cycle budget. Records the done cycle,
  // done_err, and how many cycles en_ex was high (and the last such cycle).
  task automatic wait_done(input int max_cyc, output int done_at, output logic err,
                           output int en_cnt, output int en_at);
    done_at = -1; err = 1'b0; en_cnt = 0; en_at = -1;
    while (done_at < 0 && cyc < max_cyc) begin
      tick();
      if (en_ex) begin en_cnt++; en_at = cyc; end
      if (done)  begin done_at = cyc; err = done_err; end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({en_ex, done, done_err, ser_active, ser_idx, cntrl_out, retire_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b done=%b err=%b sa=%b idx=%0d cntrl=%h rc=%0d required all zero",
               en_ex, done, done_err, ser_active, ser_idx, cntrl_out, retire_cnt);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", instr_ready);
    end
    #5 rst1_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    int d_at, e_cnt, e_at; logic err;
    issue(7'h29);
    checks++;
    if (en_ex !== 1'b0 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL arith_t0: got en_ex=%b ready=%b required 0/0", en_ex, instr_ready);
    end
    wait_done(20, d_at, err, e_cnt, e_at);
    exp_retire++;
    checks++;
    if (e_cnt !== 1 || e_at !== 1) begin
      errors++; $display("FAIL arith_en_ex: got %0d pulses last@T%0d required 1@T1", e_cnt, e_at);
    end
    checks++;
    if (d_at !== 3 || err !== 1'b0) begin
      errors++; $display("FAIL arith_done: got T%0d err=%b required T3 err=0", d_at, err);
    end
    checks++;
    if (cntrl_out !== 7'h29 || retire_cnt !== exp_retire) begin
      errors++; $display("FAIL arith_regs: got cntrl=%h rc=%0d required 29 %0d", cntrl_out, retire_cnt, exp_retire);
    end
    tick();
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL arith_t4: got ready=%b done=%b required 1/0", instr_ready, done);
    end
  endtask

  task automatic test_mem_read_and_illegal();
    int d_at, e_cnt, e_at; logic err;
    // MEM_READ uses the ALU latency.
    issue(7'h05);
    wait_done(20, d_at, err, e_cnt, e_at);
    exp_retire++;
    checks++;
    if (d_at !== 3 || err !== 1'b0 || e_cnt !== 1 || e_at !== 1 || cntrl_out !== 7'h05) begin
      errors++; $display("FAIL memrd: got done@T%0d err=%b en=%0d@T%0d cntrl=%h required T3 0 1@T1 05",
                         d_at, err, e_cnt, e_at, cntrl_out);
    end
    tick();
    // Illegal opsel 110: no issue strobe, error retire at T2.
    issue(7'h0E);
    wait_done(20, d_at, err, e_cnt, e_at);
    exp_retire++;
    checks++;
    if (d_at !== 2 || err !== 1'b1 || e_cnt !== 0) begin
      errors++; $display("FAIL illegal_110: got done@T%0d err=%b en=%0d required T2 1 0", d_at, err, e_cnt);
    end
    checks++;
    if (cntrl_out !== 7'h05 || retire_cnt !== exp_retire) begin
      errors++; $display("FAIL illegal_regs: got cntrl=%h rc=%0d required 05 %0d", cntrl_out, retire_cnt, exp_retire);
    end
    tick();
    // MEM_WRITE without imm_regn is illegal as well.
    issue(7'h04);
    wait_done(20, d_at, err, e_cnt, e_at);
    exp_retire++;
    checks++;
    if (d_at !== 2 || err !== 1'b1 || e_cnt !== 0) begin
      errors++; $display("FAIL illegal_memwr_reg: got done@T%0d err=%b en=%0d required T2 1 0", d_at, err, e_cnt);
    end
    tick();
  endtask

  task automatic test_shift_stall();
    int d_at, e_cnt, e_at; logic err;
    stall = 1'b1;             // held through T0 and T1: edges T1,T2 stalled
    issue(7'h30);
    tick();
    tick();
    stall = 1'b0;
    wait_done(30, d_at, err, e_cnt, e_at);
    exp_retire++;
    checks++;
    if (e_cnt !== 1 || e_at !== 3) begin
      errors++; $display("FAIL shift_en_ex: got %0d pulses last@T%0d required 1@T3", e_cnt, e_at);
    end
    checks++;
    if (d_at !== 6 || err !== 1'b0 || retire_cnt !== exp_retire) begin
      errors++; $display("FAIL shift_done: got T%0d err=%b rc=%0d required T6 0 %0d", d_at, err, retire_cnt, exp_retire);
    end
    tick();
  endtask

  task automatic test_serial();
    int d_at;
    int e_at;
    logic exp_act;
    logic [4:0] exp_idx;
    d_at = -1; e_at = -1;
    issue(7'h0C);
    while (d_at < 0 && cyc < 60) begin
      tick();
      if (cyc == 10) stall = 1'b1;   // sampled at edges T11..T13
      if (cyc == 13) stall = 1'b0;
      if (en_ex) e_at = cyc;
      if (done)  d_at = cyc;
      exp_act = (cyc >= 2 && cyc <= 36);
      if (!exp_act)      exp_idx = 5'd0;
      else if (cyc <= 11) exp_idx = 5'(cyc - 2);
      else if (cyc <= 14) exp_idx = 5'd9;
      else                exp_idx = 5'(cyc - 5);
      checks++;
      if (ser_active !== exp_act || ser_idx !== exp_idx) begin
        errors++; $display("FAIL serial_T%0d: got active=%b idx=%0d required %b %0d",
                           cyc, ser_active, ser_idx, exp_act, exp_idx);
      end
    end
    exp_retire++;
    checks++;
    if (e_at !== 1 || d_at !== 37 || retire_cnt !== exp_retire) begin
      errors++; $display("FAIL serial_done: got en@T%0d done@T%0d rc=%0d required T1 T37 %0d",
                         e_at, d_at, retire_cnt, exp_retire);
    end
    tick();
  endtask

  task automatic test_flush();
    int seen;
    // Flush during EXEC of a shift.
    issue(7'h30);
    tick();
    flush = 1'b1;
    tick();
    checks++;
    if (en_ex !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL flush_exec: got en=%b done=%b ready=%b required 0 0 0", en_ex, done, instr_ready);
    end
    flush = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL flush_exec_idle: got ready=%b required 1", instr_ready);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (done) seen++; end
    checks++;
    if (seen !== 0 || retire_cnt !== exp_retire) begin
      errors++; $display("FAIL flush_exec_nodone: got %0d dones rc=%0d required 0 %0d", seen, retire_cnt, exp_retire);
    end
    // Flush while in RETIRE (ARITH reaches RETIRE in T2).
    issue(7'h29);
    tick();
    tick();
    flush = 1'b1;
    seen = 0;
    tick();
    if (done) seen++;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (done) seen++; end
    checks++;
    if (seen !== 0 || retire_cnt !== exp_retire) begin
      errors++; $display("FAIL flush_retire: got %0d dones rc=%0d required 0 %0d", seen, retire_cnt, exp_retire);
    end
    // Flush in IDLE with a valid instruction: nothing is captured.
    flush = 1'b1;
    instr_valid = 1'b1;
    instr_cntrl = 7'h2D;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready: got %b required 0", instr_ready);
    end
    tick();
    flush = 1'b0;
    instr_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (en_ex || done) seen++; end
    checks++;
    if (seen !== 0 || cntrl_out !== 7'h29) begin
      errors++; $display("FAIL flush_idle_capture: got %0d activity cycles cntrl=%h required 0 29", seen, cntrl_out);
    end
    // stall and flush together in SERIAL: flush wins.
    issue(7'h0C);
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b1;
    flush = 1'b1;
    tick();
    checks++;
    if (ser_active !== 1'b0 || ser_idx !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_stall_serial: got sa=%b idx=%0d done=%b required 0 0 0", ser_active, ser_idx, done);
    end
    stall = 1'b0;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (done || ser_active) seen++; end
    checks++;
    if (seen !== 0 || retire_cnt !== exp_retire) begin
      errors++; $display("FAIL flush_stall_after: got %0d activity rc=%0d required 0 %0d", seen, retire_cnt, exp_retire);
    end
  endtask

  task automatic test_reset_serial_and_wrap();
    int d_at, e_cnt, e_at; logic err;
    issue(7'h0C);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ser_active !== 1'b1) begin
      errors++; $display("FAIL rst_pre_serial: got sa=%b required 1", ser_active);
    end
    #3 rst1_n = 1'b0;        // between edges
    #1;
    exp_retire = '0;
    checks++;
    if ({en_ex, done, done_err, ser_active, ser_idx, cntrl_out, retire_cnt} !== 32'd0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_serial: got en=%b done=%b sa=%b idx=%0d cntrl=%h rc=%0d ready=%b required zeros ready=1",
                         en_ex, done, ser_active, ser_idx, cntrl_out, retire_cnt, instr_ready);
    end
    #3 rst1_n = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || retire_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_no_partial_done: got done=%b rc=%0d required 0 0", done, retire_cnt);
    end
    // Preload the retire counter to its top value, then retire once.
    force dut.retire_cnt_q = 16'hFFFF;
    tick();
    release dut.retire_cnt_q;
    #1;
    checks++;
    if (retire_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h required ffff", retire_cnt);
    end
    issue(7'h0E);
    wait_done(20, d_at, err, e_cnt, e_at);
    checks++;
    if (d_at !== 2 || retire_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap: got done@T%0d rc=%h required T2 0000", d_at, retire_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mem_read_and_illegal();
    test_shift_stall();
    test_serial();
    test_flush();
    test_reset_serial_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
